eth_tx_fcs_ctrl: RTL and testbench



---
 rtl/eth_tx_fcs_ctrl_pkg.sv | 37 +++
 rtl/crc32_d8.sv | 42 ++++
 rtl/eth_tx_fcs_ctrl.sv | 142 ++++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_fcs_ctrl_pkg.sv
// Shared types and constants for the Ethernet TX frame sequencer.
package eth_tx_fcs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [7:0]  PAD_BYTE      = 8'h00;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  // FCS byte idx (0 goes first on the wire): inverted, bit-reversed CRC byte
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [7:0] slice;
    logic [7:0] res;
    case (idx)
      2'd0:    slice = crc[31:24];
      2'd1:    slice = crc[23:16];
      2'd2:    slice = crc[15:8];
      default: slice = crc[7:0];
    endcase
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      res[7-i] = ~slice[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// CRC-32 (802.3 polynomial) engine, one byte per cycle, data bit 0 first.
module crc32_d8
  import eth_tx_fcs_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_clr,
  input  logic        crc_en,
  input  logic [7:0]  data,
  output logic [31:0] crc_data
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_next;

  // Shift the byte through the LFSR LSB first; clear has priority over enable
  always_comb begin
    crc_next = crc_q;
    for (int unsigned i = 0; i < 8; i++) begin
      crc_next = {crc_next[30:0], 1'b0} ^ ((crc_next[31] ^ data[i]) ? CRC_POLY : '0);
    end
    crc_d = crc_q;
    if (crc_clr) begin
      crc_d = CRC_INIT;
    end else if (crc_en) begin
      crc_d = crc_next;
    end
  end

  // CRC state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_data = crc_q;

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// GMII transmit sequencer: preamble, SFD, payload, pad, FCS, inter-frame gap.
module eth_tx_fcs_ctrl
  import eth_tx_fcs_ctrl_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [15:0] IFG_LEN_W = 16'(IFG_LEN);
  localparam logic [15:0] PRE_LEN_W = 16'(PRE_LEN);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_cnt_sat;
  logic [11:0] byte_cnt_inc;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        done_q, done_d;

  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc_data;

  crc32_d8 u_crc (
    .clk      (clk),
    .rst_n    (1'b1),
    .crc_clr  (crc_clr),
    .crc_en   (crc_en),
    .data     (crc_din),
    .crc_data (crc_data)
  );

  // Next state, byte to drive, CRC control and handshake outputs
  always_comb begin
    state_d      = state_q;
    tx_en_d      = 1'b0;
    txd_d        = PAD_BYTE;
    done_d       = 1'b0;
    crc_en       = 1'b0;
    crc_din      = s_data;
    byte_cnt_d   = byte_cnt_q;
    s_ready      = 1'b0;
    tx_err       = 1'b0;
    tx_busy      = (state_q != ST_IDLE);
    crc_clr      = rst || (state_q == ST_SFD);
    cnt_inc      = cnt_q + 16'd1;
    byte_cnt_inc = {1'b0, byte_cnt_q} + 12'd1;
    byte_cnt_sat = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_inc[10:0];

    case (state_q)
      ST_IDLE: begin
        if (s_valid) state_d = ST_PRE;
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
        if (cnt_inc >= PRE_LEN_W) state_d = ST_SFD;
      end
      ST_SFD: begin
        tx_en_d    = 1'b1;
        txd_d      = SFD_BYTE;
        byte_cnt_d = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          tx_en_d    = 1'b1;
          txd_d      = s_data;
          crc_en     = 1'b1;
          byte_cnt_d = byte_cnt_sat;
          if (s_last) state_d = (byte_cnt_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
        end else begin
          // Underrun: the last accepted byte is still on the pins this cycle
          tx_err  = 1'b1;
          state_d = ST_IFG;
        end
      end
      ST_PAD: begin
        tx_en_d    = 1'b1;
        txd_d      = PAD_BYTE;
        crc_en     = 1'b1;
        crc_din    = PAD_BYTE;
        byte_cnt_d = byte_cnt_sat;
        if (byte_cnt_inc >= MIN_LEN_W) state_d = ST_FCS;
      end
      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_byte(crc_data, cnt_q[1:0]);
        if (cnt_q[1:0] == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt_inc >= IFG_LEN_W) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end

  // State, counters and registered GMII outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      tx_en_q    <= 1'b0;
      txd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Self-checking bench for eth_tx_fcs_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_tx_fcs_ctrl;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       tx_busy, tx_done, tx_err;

  logic [7:0] d0_data;
  logic       d0_valid, d0_last, d0_ready;
  logic       d0_en;
  logic [7:0] d0_txd;
  logic       d0_busy, d0_done, d0_err;

  eth_tx_fcs_ctrl #(.MIN_LEN(60), .IFG_LEN(12), .PRE_LEN(7)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  eth_tx_fcs_ctrl #(.MIN_LEN(0), .IFG_LEN(12), .PRE_LEN(7)) dut0 (
    .clk(clk), .rst(rst), .s_data(d0_data), .s_valid(d0_valid), .s_last(d0_last),
    .s_ready(d0_ready), .gmii_tx_en(d0_en), .gmii_txd(d0_txd),
    .tx_busy(d0_busy), .tx_done(d0_done), .tx_err(d0_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32 (reflected form, as in common software implementations)
  function automatic logic [31:0] ref_crc(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected wire stream for the main DUT
  logic [7:0] exp_q[$];
  bit         end_q[$];
  bit         err_q[$];
  int         gap_q[$];

  task automatic push_byte(input logic [7:0] b, input bit e, input bit r);
    exp_q.push_back(b);
    end_q.push_back(e);
    err_q.push_back(r);
  endtask

  // gap: 0 = unchecked, 12 = at least IFG, 13 = exact (s_valid held high)
  task automatic push_frame(input bq_t pl, input int ua, input int gap);
    bq_t body;
    logic [31:0] c;
    gap_q.push_back(gap);
    for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0, 1'b0);
    push_byte(8'hD5, 1'b0, 1'b0);
    if (ua > 0) begin
      for (int i = 0; i < ua; i++) push_byte(pl[i], 1'b0, i == ua - 1);
    end else begin
      body = pl;
      while (body.size() < 60) body.push_back(8'h00);
      foreach (body[i]) push_byte(body[i], 1'b0, 1'b0);
      c = ref_crc(body);
      for (int k = 0; k < 4; k++) push_byte(c[8*k +: 8], k == 3, 1'b0);
    end
  endtask

  // Per-cycle compare of the main DUT against the expected stream
  bit mon_en = 1'b0;
  bit in_frame = 1'b0;
  bit expect_low = 1'b0;
  bit prev_en = 1'b0;
  int low_run = 0;
  int run_len = 0;
  int last_run = 0;

  always @(negedge clk) begin : mon
    int g;
    logic [7:0] b;
    bit e, r;
    if (!mon_en) begin
      in_frame = 1'b0; expect_low = 1'b0; prev_en = 1'b0; low_run = 0; run_len = 0;
    end else begin
      if (gmii_tx_en) begin
        if (!prev_en && gap_q.size() > 0) begin
          g = gap_q.pop_front();
          if (g == 13) chk("ifg_exact", low_run, 13);
          else if (g == 12) chk("ifg_min", low_run >= 12, 1);
        end
        if (expect_low) begin
          chk("tx_en_after_frame_end", gmii_tx_en, 1'b0);
          expect_low = 1'b0;
        end
        low_run = 0;
        run_len++;
        if (exp_q.size() == 0) begin
          chk("tx_en_unexpected", gmii_tx_en, 1'b0);
        end else begin
          b = exp_q.pop_front();
          e = end_q.pop_front();
          r = err_q.pop_front();
          in_frame = 1'b1;
          chk("txd", gmii_txd, b);
          chk("tx_done", tx_done, e);
          chk("tx_err", tx_err, r);
          chk("tx_busy", tx_busy, 1'b1);
          if (e || r) begin
            in_frame = 1'b0;
            expect_low = 1'b1;
          end
        end
      end else begin
        if (prev_en) last_run = run_len;
        run_len = 0;
        if (expect_low) begin
          chk("tx_en_low_after_frame", gmii_tx_en, 1'b0);
          expect_low = 1'b0;
        end
        if (in_frame) begin
          chk("tx_en_gap_in_frame", gmii_tx_en, 1'b1);
          in_frame = 1'b0;
        end
        chk("tx_done_idle", tx_done, 1'b0);
        chk("tx_err_idle", tx_err, 1'b0);
        low_run++;
      end
      prev_en = gmii_tx_en;
    end
  end

  // Capture everything dut0 puts on the wire
  logic [7:0] cap0[$];
  int done0_idx = -1;
  always @(negedge clk) begin
    if (d0_en) begin
      cap0.push_back(d0_txd);
      if (d0_done) done0_idx = cap0.size() - 1;
    end
  end

  // Drive one frame on the main DUT; ua > 0 drops s_valid before byte ua
  task automatic send_frame(input bq_t pl, input int ua, input bit hold);
    int i, n, cyc;
    n = pl.size();
    i = 0;
    cyc = 0;
    s_valid = 1'b1;
    s_data  = pl[0];
    s_last  = (n == 1);
    while (i < n) begin
      if (cyc >= 600) begin
        tests++; fails++;
        $display("FAIL driver_timeout: byte %0d of %0d not accepted", i, n);
        s_valid = 1'b0; s_last = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
      if (s_ready) begin
        @(posedge clk);
        #1;
        i++;
        if (i == ua) begin
          s_valid = 1'b0; s_last = 1'b0;
          break;
        end
        if (i < n) begin
          s_data = pl[i];
          s_last = (i == n - 1);
        end else begin
          s_last = 1'b0;
          if (!hold) s_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !in_frame && !expect_low && !gmii_tx_en) break;
    end
    chk("wait_idle_in_time", c < 3000, 1'b1);
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  int  next_gap = 0;
  bit  prev_hold = 1'b0;

  initial begin : main
    bq_t pl, pl2, body;
    bq_t exp0;
    logic [31:0] c;
    logic [7:0] fcs1;
    int n, ua, cnt, i0, cyc;
    bit hold, found;

    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    d0_valid = 1'b0; d0_last = 1'b0; d0_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_tx_err", tx_err, 1'b0);
    rst = 1'b0;

    // Pin the reference CRC to the well-known check value
    pl = {};
    for (int k = 0; k < 9; k++) pl.push_back(8'h31 + 8'(k));
    chk("ref_crc_check_value", ref_crc(pl), 32'hCBF4_3926);

    // MIN_LEN = 0 instance: "123456789" with no padding
    i0 = 0; cyc = 0;
    d0_valid = 1'b1; d0_data = pl[0]; d0_last = 1'b0;
    while (i0 < 9 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (d0_ready) begin
        @(posedge clk);
        #1;
        i0++;
        if (i0 < 9) begin
          d0_data = pl[i0];
          d0_last = (i0 == 8);
        end else begin
          d0_valid = 1'b0; d0_last = 1'b0;
        end
      end
    end
    repeat (30) @(posedge clk);
    for (int k = 0; k < 7; k++) exp0.push_back(8'h55);
    exp0.push_back(8'hD5);
    foreach (pl[k]) exp0.push_back(pl[k]);
    exp0.push_back(8'h26); exp0.push_back(8'h39); exp0.push_back(8'hF4); exp0.push_back(8'hCB);
    chk("min0_tx_en_cycles", cap0.size(), 21);
    chk("min0_done_on_last_fcs", done0_idx, 20);
    for (int k = 0; k < 21; k++) begin
      if (k < cap0.size()) chk("min0_txd", cap0[k], exp0[k]);
    end

    mon_en = 1'b1;
    next_gap = 0;

    // 14-byte payload: 46 pad bytes, 72 tx_en cycles
    pl = rand_payload(14);
    push_frame(pl, -1, next_gap);
    send_frame(pl, -1, 1'b0);
    wait_idle();
    chk("len14_tx_en_cycles", last_run, 72);
    next_gap = 12;

    // Payload exactly MIN_LEN: no pad, same 72 cycles
    pl = rand_payload(60);
    push_frame(pl, -1, next_gap);
    send_frame(pl, -1, 1'b0);
    wait_idle();
    chk("len60_tx_en_cycles", last_run, 72);

    // Back-to-back 64-byte frames with s_valid held high
    pl = rand_payload(64);
    pl2 = rand_payload(64);
    push_frame(pl, -1, 12);
    send_frame(pl, -1, 1'b1);
    push_frame(pl2, -1, 13);
    send_frame(pl2, -1, 1'b0);
    wait_idle();
    chk("len64_tx_en_cycles", last_run, 76);

    // Underrun at payload byte 20
    pl = rand_payload(40);
    push_frame(pl, 20, 12);
    send_frame(pl, 20, 1'b0);
    wait_idle();
    chk("underrun_tx_en_cycles", last_run, 28);

    // Randomized frames, optional hold and occasional underrun
    prev_hold = 1'b0;
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(1, 80);
      pl = rand_payload(n);
      ua = (n >= 2 && $urandom_range(0, 7) == 0) ? $urandom_range(1, n - 1) : -1;
      hold = (ua < 0) && ($urandom_range(0, 2) == 0);
      if (!prev_hold) repeat ($urandom_range(0, 20)) @(posedge clk);
      push_frame(pl, ua, prev_hold ? 13 : 12);
      send_frame(pl, ua, hold);
      prev_hold = hold;
    end
    wait_idle();

    // Reset while FCS byte 1 is on the pins
    mon_en = 1'b0;
    @(negedge clk);
    exp_q.delete(); end_q.delete(); err_q.delete(); gap_q.delete();
    repeat (15) @(posedge clk);
    pl = rand_payload(14);
    body = pl;
    while (body.size() < 60) body.push_back(8'h00);
    c = ref_crc(body);
    fcs1 = c[15:8];
    found = 1'b0;
    fork
      send_frame(pl, -1, 1'b0);
      begin
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (gmii_tx_en) begin
            if (cnt == 69) begin
              chk("fcs1_before_rst", gmii_txd, fcs1);
              rst = 1'b1;
              found = 1'b1;
              break;
            end
            cnt++;
          end
        end
      end
    join
    chk("rst_test_reached_fcs1", found, 1'b1);
    @(negedge clk);
    chk("midrst_tx_en", gmii_tx_en, 1'b0);
    chk("midrst_txd", gmii_txd, 8'h00);
    chk("midrst_tx_busy", tx_busy, 1'b0);
    chk("midrst_s_ready", s_ready, 1'b0);
    chk("midrst_tx_done", tx_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_still_idle", gmii_tx_en, 1'b0);
    mon_en = 1'b1;

    // Next frame after reset must carry a freshly cleared CRC
    pl = rand_payload(25);
    push_frame(pl, -1, 0);
    send_frame(pl, -1, 1'b0);
    wait_idle();
    chk("after_rst_tx_en_cycles", last_run, 72);

    repeat (20) @(posedge clk);
    chk("expected_stream_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
